// File: rtl/dom_sqscmul_share_codec.sv
// Share codec for a DOM masked GF(2^2) multiplier: masks operands into Boolean shares,
// recombines the returned result shares in issue order. `SQSCMUL_CODEC_STALL_CNT_EN adds StallCntxDO.
module dom_sqscmul_share_codec #(
    parameter int SHARES     = 2,
    parameter int LATENCY    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    ClkxCI,
    input  logic                    RstxBI,
    input  logic [3:0]              DataxDI,
    input  logic                    DataValidxSI,
    output logic                    DataReadyxSO,
    input  logic [4*(SHARES-1)-1:0] RndxDI,
    input  logic                    RndValidxSI,
    output logic                    RndReadyxSO,
    output logic [4*SHARES-1:0]     _XxDO,
    input  logic [2*SHARES-1:0]     _QxDI,
    output logic [1:0]              ResultxDO,
    output logic                    ResultValidxSO,
    input  logic                    ResultReadyxSI
`ifdef SQSCMUL_CODEC_STALL_CNT_EN
    ,
    output logic [15:0]             StallCntxDO
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

    logic [AW:0]          wrPtr;
    logic [AW:0]          rdPtr;
    logic [CW-1:0]        occupancy;
    logic [CW-1:0]        inFlight;
    logic [CW:0]          committed;
    logic [LATENCY-1:0]   validSr;
    logic [1:0]           fifoMem [FIFO_DEPTH];
    logic                 fifoEmpty;
    logic                 fifoFull;
    logic                 hasCredit;
    logic                 issue;
    logic                 sampleEn;
    logic                 popEn;
    logic [3:0]           maskedShare0;
    logic [4*SHARES-1:0]  sharesNext;
    logic [1:0]           recombined;

    // Credit covers both buffered results and items still inside the multiplier
    assign occupancy = wrPtr - rdPtr;
    assign fifoEmpty = (wrPtr == rdPtr);
    assign fifoFull  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign committed = {1'b0, occupancy} + {1'b0, inFlight};
    assign hasCredit = !fifoFull && (committed < DEPTH_W);

    assign issue        = RstxBI && DataValidxSI && RndValidxSI && hasCredit;
    assign DataReadyxSO = issue;
    assign RndReadyxSO  = issue;

    assign sampleEn       = validSr[LATENCY-1];
    assign ResultValidxSO = !fifoEmpty;
    assign popEn          = ResultValidxSO && ResultReadyxSI;
    assign ResultxDO      = fifoEmpty ? 2'b00 : fifoMem[rdPtr[AW-1:0]];

    // Share 0 carries the data folded with every random slice; the plain operand never leaves
    always_comb begin
        maskedShare0 = DataxDI;
        for (int i = 1; i < SHARES; i++) begin
            maskedShare0 = maskedShare0 ^ RndxDI[4*i-4 +: 4];
        end
        sharesNext = {RndxDI, maskedShare0};
    end

    always_comb begin
        recombined = 2'b00;
        for (int i = 0; i < SHARES; i++) begin
            recombined = recombined ^ _QxDI[2*i +: 2];
        end
    end

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            _XxDO    <= '0;
            validSr  <= '0;
            inFlight <= '0;
            wrPtr    <= '0;
            rdPtr    <= '0;
        end else begin
            if (issue) begin
                _XxDO <= sharesNext;
            end
            validSr[0] <= issue;
            for (int i = 1; i < LATENCY; i++) begin
                validSr[i] <= validSr[i-1];
            end
            inFlight <= inFlight + CW'(issue) - CW'(sampleEn);
            if (sampleEn) begin
                wrPtr <= wrPtr + PTR_ONE;
            end
            if (popEn) begin
                rdPtr <= rdPtr + PTR_ONE;
            end
        end
    end

    // Storage needs no reset: pointers alone decide what is visible
    always_ff @(posedge ClkxCI) begin
        if (sampleEn) begin
            fifoMem[wrPtr[AW-1:0]] <= recombined;
        end
    end

`ifdef SQSCMUL_CODEC_STALL_CNT_EN
    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            StallCntxDO <= '0;
        end else if (DataValidxSI && !issue && (StallCntxDO != 16'hFFFF)) begin
            StallCntxDO <= StallCntxDO + 16'd1;
        end
    end
`endif

endmodule
